// File: rtl/axis_packet_reverser.sv
// Store-and-forward AXI-Stream stage: buffers one tlast-delimited packet and
// re-emits its beats in reverse order, with packet-count and truncation status.
module axis_packet_reverser #(
    parameter int data_width_p  = 32,
    parameter int max_beats_p   = 16,
    parameter int count_width_p = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [data_width_p-1:0]  s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [data_width_p-1:0]  m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [count_width_p-1:0] pkt_count_o,
    output logic                     trunc_o
);

    localparam int ptr_width_lp = (max_beats_p > 1) ? $clog2(max_beats_p) : 1;
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(max_beats_p - 1);

    typedef enum logic {FILL, DRAIN} state_e;

    state_e                    state_q, state_d;
    logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [count_width_p-1:0]  pkt_count_q, pkt_count_d;
    logic                      trunc_q, trunc_d;
    logic [data_width_p-1:0]   mem_q [max_beats_p];
    logic [data_width_p-1:0]   mem_d [max_beats_p];
    logic                      in_fire, out_fire;

    // A beat transfers on a rising edge where valid and ready are both high;
    // valid never waits on ready, and data/last hold while valid && !ready.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pkt_count_d   = pkt_count_q;
        trunc_d       = trunc_q;
        mem_d         = mem_q;
        in_fire       = 1'b0;
        out_fire      = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = mem_q[rd_ptr_q];

        unique case (state_q)
            FILL: begin
                s_axis_tready = 1'b1;
                in_fire       = s_axis_tvalid;
                if (in_fire) begin
                    mem_d[wr_ptr_q] = s_axis_tdata;
                    if (s_axis_tlast || (wr_ptr_q == last_ptr_lp)) begin
                        rd_ptr_d = wr_ptr_q;
                        wr_ptr_d = '0;
                        state_d  = DRAIN;
                        // A full buffer without tlast closes the packet early.
                        if (!s_axis_tlast) begin
                            trunc_d = 1'b1;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q + ptr_width_lp'(1);
                    end
                end
            end
            DRAIN: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (rd_ptr_q == '0);
                out_fire      = m_axis_tready;
                if (out_fire) begin
                    if (rd_ptr_q != '0) begin
                        rd_ptr_d = rd_ptr_q - ptr_width_lp'(1);
                    end else begin
                        state_d     = FILL;
                        pkt_count_d = pkt_count_q + count_width_p'(1);
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        // Outputs present the idle FILL face for the whole reset cycle.
        if (!aresetn) begin
            s_axis_tready = 1'b1;
            m_axis_tvalid = 1'b0;
            m_axis_tlast  = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            trunc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_count_q <= pkt_count_d;
            trunc_q     <= trunc_d;
        end
    end

    // Buffer contents are deliberately left unreset; the pointers decide validity.
    always_ff @(posedge aclk) begin
        mem_q <= mem_d;
    end

    assign pkt_count_o = pkt_count_q;
    assign trunc_o     = trunc_q;

endmodule

// File: tb/tb_axis_packet_reverser.sv
// Randomized bench for axis_packet_reverser against a packet-level reverse model.
module tb_axis_packet_reverser;

    localparam int DW = 32;
    localparam int MB = 16;
    localparam int CW = 2;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [CW-1:0] pkt_count_o;
    logic          trunc_o;

    axis_packet_reverser #(
        .data_width_p (DW),
        .max_beats_p  (MB),
        .count_width_p(CW)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .pkt_count_o  (pkt_count_o),
        .trunc_o      (trunc_o)
    );

    // clock / reset
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // scoreboard: {last, data} of every beat the DUT must still emit, in order
    logic [DW:0]   exp_q[$];
    logic [DW:0]   stim_q[$];
    logic [DW-1:0] model_buf[$];
    int            model_pkts;
    bit            model_trunc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic void model_reset();
        exp_q.delete();
        stim_q.delete();
        model_buf.delete();
        model_pkts  = 0;
        model_trunc = 0;
    endfunction

    // A packet closes on tlast or when it reaches MB beats; it comes out reversed.
    function automatic void model_add(input logic [DW-1:0] d, input bit last);
        logic lb;
        model_buf.push_back(d);
        if (last || model_buf.size() == MB) begin
            if (!last) model_trunc = 1;
            for (int i = model_buf.size() - 1; i >= 0; i--) begin
                lb = (i == 0);
                exp_q.push_back({lb, model_buf[i]});
            end
            model_buf.delete();
        end
    endfunction

    function automatic void add_beat(input logic [DW-1:0] d, input bit last);
        logic lb;
        lb = last;
        stim_q.push_back({lb, d});
        model_add(d, last);
    endfunction

    // driver: input side; every task starts and ends at a falling edge
    task automatic drive_stream(input int gap_max);
        logic [DW:0] b;
        int          cnt;
        int          wait_n;
        bit          closes;
        cnt = 0;
        while (stim_q.size() > 0) begin
            b = stim_q.pop_front();
            repeat ($urandom_range(0, gap_max)) begin
                s_axis_tvalid = 1'b0;
                @(negedge aclk);
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = b[DW-1:0];
            s_axis_tlast  = b[DW];
            wait_n = 0;
            while (!s_axis_tready && wait_n < 400) begin
                @(negedge aclk);
                wait_n++;
            end
            if (wait_n >= 400) begin
                check("in_timeout", 0, 1);
                s_axis_tvalid = 1'b0;
                return;
            end
            @(negedge aclk);
            s_axis_tvalid = 1'b0;
            cnt++;
            closes = b[DW] || (cnt == MB);
            if (closes) cnt = 0;
            check("drain_start", {31'b0, m_axis_tvalid}, {31'b0, closes});
        end
        s_axis_tvalid = 1'b0;
    endtask

    // monitor: output side; mode 0 always ready, 1 pattern 1,0,0, 2 random
    task automatic run_monitor(input int n, input int mode);
        int            got, cyc, ph;
        bit            stalled, cnt_pending;
        logic [DW-1:0] pd;
        logic          pl;
        logic [DW:0]   e;
        got = 0; cyc = 0; ph = 0; stalled = 0; cnt_pending = 0;
        pd = '0; pl = 1'b0;
        while (cyc < 3000) begin
            if (cnt_pending) begin
                check("pkt_count", {30'b0, pkt_count_o}, model_pkts % (1 << CW));
                check("trunc", {31'b0, trunc_o}, {31'b0, model_trunc});
                cnt_pending = 0;
            end
            if (got >= n) break;
            case (mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (ph % 3 == 0);
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            ph++;
            if (stalled) begin
                check("hold_valid", {31'b0, m_axis_tvalid}, 1);
                check("hold_data", m_axis_tdata, pd);
                check("hold_last", {31'b0, m_axis_tlast}, {31'b0, pl});
            end
            if (m_axis_tvalid) check("in_ready_drain", {31'b0, s_axis_tready}, 0);
            stalled = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pl = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", m_axis_tdata, e[DW-1:0]);
                    check("out_last", {31'b0, m_axis_tlast}, {31'b0, e[DW]});
                    if (e[DW]) begin
                        model_pkts++;
                        cnt_pending = 1;
                    end
                end
                got++;
            end
            @(negedge aclk);
            cyc++;
        end
        if (got < n) check("out_timeout", got, n);
        m_axis_tready = 1'b0;
    endtask

    task automatic apply_reset();
        s_axis_tvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        check("rst_during_in_ready", {31'b0, s_axis_tready}, 1);
        check("rst_during_out_valid", {31'b0, m_axis_tvalid}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        model_reset();
        check("rst_in_ready", {31'b0, s_axis_tready}, 1);
        check("rst_out_valid", {31'b0, m_axis_tvalid}, 0);
        check("rst_out_last", {31'b0, m_axis_tlast}, 0);
        check("rst_pkt_count", {30'b0, pkt_count_o}, 0);
        check("rst_trunc", {31'b0, trunc_o}, 0);
    endtask

    task automatic run_packet(input int gap_max, input int mode);
        int n;
        n = exp_q.size();
        fork
            drive_stream(gap_max);
            run_monitor(n, mode);
        join
    endtask

    task automatic random_packet(input int len);
        for (int i = 0; i < len; i++) add_beat($urandom, i == len - 1);
    endtask

    int wrap_exp[5] = '{1, 2, 3, 0, 1};

    initial begin
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        model_reset();
        repeat (2) @(negedge aclk);
        apply_reset();

        // basic reverse of 0x00..0x0F
        for (int i = 0; i < 16; i++) add_beat(i, i == 15);
        run_packet(0, 0);

        // backpressure with input gaps
        for (int i = 0; i < 4; i++) add_beat(32'hA0 + i, i == 3);
        run_packet(3, 1);

        // single beat
        add_beat(32'h55, 1);
        run_packet(0, 0);

        // truncation: 20 beats, tlast only on the last one
        for (int i = 0; i < 20; i++) add_beat(i, i == 19);
        run_packet(1, 2);

        // reset during FILL after 5 beats
        for (int i = 0; i < 5; i++) add_beat(32'h100 + i, 0);
        drive_stream(0);
        apply_reset();
        random_packet(16);
        run_packet(1, 2);

        // reset during DRAIN after 3 output beats
        random_packet(16);
        fork
            drive_stream(0);
            run_monitor(3, 0);
        join
        apply_reset();
        random_packet(16);
        run_packet(0, 0);

        // counter wrap over five single-beat packets
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            add_beat($urandom, 1);
            run_packet(0, 0);
            check("wrap_seq", {30'b0, pkt_count_o}, wrap_exp[k]);
        end

        // random packets
        for (int p = 0; p < 20; p++) begin
            random_packet($urandom_range(1, MB));
            run_packet($urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
